pipe_fetch_ctrl: RTL and testbench
==================================

Name: pipe_fetch_ctrl

Overview:
- Fetch-stage controller for the pipelined CPU. It owns the program counter and sequences it against a variable-latency instruction memory.
- Selects the next PC from sequential, branch, jump-register and jump sources.
- Buffers a redirect that arrives while a fetch is still outstanding.
- Drives valid/flush qualifiers into the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0008, exception handler address (used only with PIPEFETCH_EXC_EN)

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
clr  in  1  synchronous, active-high reset
stall  in  1  ID-stage hazard stall; hold PC, pcsrc not final
pcsrc  in  2  next-PC select from ID: 00 seq, 01 branch, 10 jr, 11 jump
bpc  in  32  branch target
rpc  in  32  jump-register target
jpc  in  32  jump target
imem_ack  in  1  instruction memory has returned the word for pc this cycle
pc  out  32  current fetch address
imem_req  out  1  fetch request for pc
if_valid  out  1  fetched word is to be written into IF/ID this cycle
if_flush  out  1  kill the instruction in IF/ID (wrong path)

Behaviour:
- Reset (clr=1 at edge) sets: state=BOOT, pc=RESET_PC, pending flag pend_v=0, pend_pc=0. Outputs are combinational from state; in BOOT: imem_req=0, if_valid=0, if_flush=0.
- Reset mid-operation: reset overrides everything, and any pending redirect is discarded.
- Redirect event: r = (pcsrc!=00) & ~stall. Target = bpc/rpc/jpc per pcsrc, with bits [1:0] forced to 00.
- States:
  - BOOT: imem_req=0; goes unconditionally to FETCH next cycle.
  - FETCH: imem_req=1.
    - ack & r: pc<=target, if_valid=0, if_flush=1.
    - ack & ~r & ~stall: pc<=pc+4, mod 2^32, so 32'hFFFF_FFFC wraps to 0; if_valid=1.
    - ack & stall: pc held, if_valid=0; the word is dropped and refetched.
    - ~ack & r: pend_pc<=target, pend_v<=1, if_flush=1, pc held, next state WAIT.
    - ~ack & ~r: stay in FETCH, pc held, if_valid=0.
  - WAIT: imem_req=1 (outstanding fetch must complete); if_valid=0 always, since the returning word is wrong-path.
    - r while in WAIT: pend_pc overwritten (latest wins), if_flush=1.
    - ack: pc<=pend_pc, or the new target if r occurs the same cycle; pend_v<=0; next state FETCH.
- if_flush=1 in exactly the cycles where r=1, regardless of imem_ack.
- Latency:
  - PC advances on the same edge as an accepted ack.
  - Redirect with ack takes effect on the next edge: first target fetch is issued the cycle after the redirect.
- imem_req never deasserts while a fetch is outstanding, except on reset.

Optional Feature:
Macro PIPEFETCH_EXC_EN.
- Defined: adds ports exc_req in 1, exc_ack out 1, epc out 32 (epc resets to 0).
  - exc_req has priority over r and stall.
  - Exception in FETCH with ack: pc<=EXC_VECTOR, epc<=pc, exc_ack=1, if_flush=1.
  - Exception without ack: treated as a pending redirect to EXC_VECTOR, with epc captured at acceptance.
  - exc_ack pulses for one cycle per accepted exception.
  - exc_req is ignored in BOOT.
- Undefined: these ports and their logic are absent; behaviour is exactly as above.

Test Plan:
- Reset sequence: clr=1 for 2 cycles, then 0, imem_ack=1 → pc=0, imem_req=0 in BOOT, then pc=0,4,8,12 on successive cycles with if_valid=1.
- Stall: from pc=8, stall=1 for 3 cycles with ack=1 → pc stays 8, if_valid=0 for 3 cycles, then 12.
- Branch with ack: at pc=16, pcsrc=01, bpc=32'h100 → if_flush=1, next pc=0x100, if_valid=0 that cycle.
- Redirect while memory slow: ack=0, pcsrc=11, jpc=32'h203 → state WAIT, if_flush=1, pc held. Ack arrives 3 cycles later → pc=0x200, if_valid=0 on that ack.
- Wrap and mid-op reset: pc=32'hFFFF_FFFC with ack → pc=0. Separately, clr=1 while in WAIT → pc=RESET_PC, pend_v=0, BOOT.
- PIPEFETCH_EXC_EN: exc_req=1 with pcsrc=01 at pc=0x40, ack=1 → pc=0x8, epc=0x40, exc_ack pulses once, branch ignored.

Source files
------------

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences it against a variable-latency
// instruction memory, and buffers a redirect that lands during an outstanding fetch.
// Optional exception entry is enabled by defining PIPEFETCH_EXC_EN.
module pipe_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        stall,
   input  logic [1:0]  pcsrc,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   input  logic        imem_ack,
`ifdef PIPEFETCH_EXC_EN
   input  logic        exc_req,
   output logic        exc_ack,
   output logic [31:0] epc,
`endif
   output logic [31:0] pc,
   output logic        imem_req,
   output logic        if_valid,
   output logic        if_flush
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] pend_pc, pend_pc_nxt;
   logic        pend_v, pend_v_nxt;

   logic [31:0] raw_tgt;
   logic [31:0] tgt;
   logic        redir;
   logic        go;

   always_comb begin
      raw_tgt = '0;
      unique case (pcsrc)
         2'b01:   raw_tgt = bpc;
         2'b10:   raw_tgt = rpc;
         2'b11:   raw_tgt = jpc;
         default: raw_tgt = '0;
      endcase
   end

   assign redir = (pcsrc != 2'b00) & ~stall;

`ifdef PIPEFETCH_EXC_EN
   logic        take_exc;
   logic [31:0] epc_nxt;

   // An exception outranks both the ID redirect and the hazard stall.
   assign take_exc = exc_req & (state != BOOT);
   assign go       = take_exc | redir;
   assign tgt      = take_exc ? (EXC_VECTOR & ~32'h3) : (raw_tgt & ~32'h3);
`else
   assign go  = redir;
   assign tgt = raw_tgt & ~32'h3;
`endif

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      pend_pc_nxt = pend_pc;
      pend_v_nxt  = pend_v;
      imem_req    = 1'b0;
      if_valid    = 1'b0;
      if_flush    = 1'b0;
`ifdef PIPEFETCH_EXC_EN
      exc_ack     = take_exc;
      epc_nxt     = take_exc ? pc : epc;
`endif
      unique case (state)
         BOOT: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if_flush = go;
            if (imem_ack) begin
               if (go) begin
                  pc_nxt = tgt;
               end else if (!stall) begin
                  pc_nxt   = pc + 32'd4;
                  if_valid = 1'b1;
               end
            end else if (go) begin
               pend_pc_nxt = tgt;
               pend_v_nxt  = 1'b1;
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            // The word returning here belongs to the abandoned path, so it is never written.
            imem_req = 1'b1;
            if_flush = go;
            if (go) pend_pc_nxt = tgt;
            if (imem_ack) begin
               if (go)          pc_nxt = tgt;
               else if (pend_v) pc_nxt = pend_pc;
               pend_v_nxt = 1'b0;
               state_nxt  = FETCH;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= BOOT;
         pc      <= RESET_PC;
         pend_pc <= '0;
         pend_v  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         pend_pc <= pend_pc_nxt;
         pend_v  <= pend_v_nxt;
      end
   end

`ifdef PIPEFETCH_EXC_EN
   always_ff @(posedge clk) begin
      if (clr) epc <= '0;
      else     epc <= epc_nxt;
   end
`endif

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Scoreboard bench for pipe_fetch_ctrl: a cycle-level reference model pushes expected
// outputs per cycle, and an independent monitor pops and compares them against the DUT.
module tb_pipe_fetch_ctrl;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  pcsrc = 2'b00;
   logic [31:0] bpc = '0, rpc = '0, jpc = '0;
   logic        imem_ack = 1'b0;
   logic [31:0] pc;
   logic        imem_req, if_valid, if_flush;

   pipe_fetch_ctrl #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0008)) dut (
      .clk(clk), .clr(clr), .stall(stall), .pcsrc(pcsrc),
      .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_ack(imem_ack),
      .pc(pc), .imem_req(imem_req), .if_valid(if_valid), .if_flush(if_flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          care;
      int          cyc;
      logic [31:0] pc;
      logic        req;
      logic        valid;
      logic        flush;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference state: "booting" = first cycle after reset, "wrong_path" = a redirect is
   // waiting behind an outstanding fetch whose word must be thrown away.
   logic [31:0] m_pc = '0;
   logic [31:0] m_pend = '0;
   bit          m_booting = 1'b1;
   bit          m_wrong_path = 1'b0;

   task automatic step(input logic c, input logic s, input logic [1:0] ps,
                       input logic [31:0] b, input logic [31:0] r, input logic [31:0] j,
                       input logic a);
      exp_t        e;
      bit          redirect;
      logic [31:0] dest;
      @(negedge clk);
      clr = c; stall = s; pcsrc = ps; bpc = b; rpc = r; jpc = j; imem_ack = a;
      cyc++;
      #1;
      redirect = (ps != 2'b00) && !s;
      dest = (ps == 2'b01) ? b : (ps == 2'b10) ? r : j;
      dest = {dest[31:2], 2'b00};
      e.cyc = cyc; e.care = !c; e.pc = m_pc;
      e.req = 1'b0; e.valid = 1'b0; e.flush = 1'b0;
      if (c) begin
         m_pc = 32'h0000_0000; m_pend = '0; m_booting = 1'b1; m_wrong_path = 1'b0;
      end else if (m_booting) begin
         m_booting = 1'b0;
      end else begin
         e.req   = 1'b1;
         e.flush = redirect;
         if (m_wrong_path) begin
            if (redirect) m_pend = dest;
            if (a) begin
               m_pc = m_pend;
               m_wrong_path = 1'b0;
            end
         end else if (a) begin
            if (redirect) m_pc = dest;
            else if (!s) begin
               e.valid = 1'b1;
               m_pc = m_pc + 32'd4;
            end
         end else if (redirect) begin
            m_pend = dest;
            m_wrong_path = 1'b1;
         end
      end
      expq.push_back(e);
   endtask

   task automatic check(input string name, input int c, input logic [31:0] act,
                        input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         if (e.care) begin
            check("pc",       e.cyc, pc,                {31'd0, 1'b0} | e.pc);
            check("imem_req", e.cyc, {31'd0, imem_req}, {31'd0, e.req});
            check("if_valid", e.cyc, {31'd0, if_valid}, {31'd0, e.valid});
            check("if_flush", e.cyc, {31'd0, if_flush}, {31'd0, e.flush});
         end
      end
   end

   initial begin
      logic [1:0] ps;
      // Reset, then sequential fetch 0,4,8
      step(1, 0, 2'b00, '0, '0, '0, 1);
      step(1, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      // Stall at pc=8 for three cycles, then resume to 12, 16
      repeat (3) step(0, 1, 2'b01, 32'h40, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      // Branch with ack at pc=16
      step(0, 0, 2'b01, 32'h100, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      // Jump while memory is slow; ack three cycles later
      step(0, 0, 2'b11, '0, '0, 32'h203, 0);
      step(0, 0, 2'b00, '0, '0, '0, 0);
      step(0, 0, 2'b00, '0, '0, '0, 0);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      // Latest redirect wins while waiting
      step(0, 0, 2'b10, '0, 32'h300, '0, 0);
      step(0, 0, 2'b01, 32'h404, '0, '0, 0);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      // Wrap from FFFF_FFFC to 0
      step(0, 0, 2'b11, '0, '0, 32'hFFFF_FFFF, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      // Reset while a redirect is pending
      step(0, 0, 2'b11, '0, '0, 32'h500, 0);
      step(1, 0, 2'b00, '0, '0, '0, 0);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ps = ($urandom_range(99) < 70) ? 2'b00 : 2'($urandom_range(3, 1));
         step(($urandom_range(199) < 3), ($urandom_range(99) < 20), ps,
              $urandom, $urandom, $urandom, ($urandom_range(99) < 60));
      end
      step(0, 0, 2'b00, '0, '0, '0, 0);
      @(negedge clk);
      #5;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
